fp_div_seq: RTL and testbench

- Sequential IEEE-754 single-precision divider, Out = A / B, with a start/done handshake.
- Sits directly upstream of the Newton-Raphson square-root datapath. The sqrt controller issues A / x_n each iteration and consumes Out to form x_{n+1} = (x_n + A/x_n) / 2.
- Fixed latency, so the sqrt controller counts cycles and does not track per-case timing.
- Restoring mantissa division, one quotient bit per cycle, round-to-nearest-even.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_unpack.sv | 30 +++
 rtl/fp_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_fp_div_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the divider and the sqrt datapath.
package fp_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        ITER   = 2'd2,
        ROUND  = 2'd3
    } div_state_e;

    function automatic logic [31:0] signed_inf(input logic sign);
        return {sign, POS_INF[30:0]};
    endfunction

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one single-precision operand into fields and classifies it; denormals read as zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W:0]   mant,
    output fp_class_e         cls
);

    // field split and classification
    always_comb begin
        sign = op[31];
        exp  = op[30:23];
        mant = {1'b1, op[22:0]};
        if (op[30:23] == 8'd0) begin
            cls = ZERO;
        end else if (op[30:23] == 8'hFF) begin
            if (op[22:0] != 23'd0) begin
                cls = NAN;
            end else begin
                cls = INF;
            end
        end else begin
            cls = NORMAL;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Fixed-latency sequential single-precision divider: restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, QBITS+2 cycles start to done.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        fp_clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);

    localparam int CNT_W = $clog2(QBITS);

    div_state_e        state_r, state_s;
    logic [31:0]       a_r, b_r;
    logic              sa_s, sb_s;
    logic [7:0]        ea_s, eb_s;
    logic [23:0]       ma_s, mb_s;
    fp_class_e         ca_s, cb_s;
    logic signed [9:0] ediff_s;

    logic              sign_r;
    fp_class_e         cls_a_r, cls_b_r;
    logic [23:0]       mb_r;
    logic [24:0]       rem_r;
    logic [QBITS-1:0]  q_r;
    logic signed [9:0] e_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r;
    logic [31:0]       out_r;

    logic              ge_s;
    logic [23:0]       sub_s;
    logic [QBITS-2:0]  qn_s;
    logic signed [9:0] en_s, ef_s;
    logic              guard_s, sticky_s, inc_s, carry_s;
    logic [22:0]       frac_s;
    logic [31:0]       result_s;

    fp_unpack u_unpack_a (.op(a_r), .sign(sa_s), .exp(ea_s), .mant(ma_s), .cls(ca_s));
    fp_unpack u_unpack_b (.op(b_r), .sign(sb_s), .exp(eb_s), .mant(mb_s), .cls(cb_s));

    assign ediff_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = UNPACK;
                end else begin
                    state_s = IDLE;
                end
            end
            UNPACK: state_s = ITER;
            ITER: begin
                if (cnt_r == CNT_W'(QBITS - 1)) begin
                    state_s = ROUND;
                end else begin
                    state_s = ITER;
                end
            end
            ROUND:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge fp_clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // one restoring step; a non-subtracting remainder is already below 2^24
    always_comb begin
        ge_s = (rem_r >= {1'b0, mb_r});
        if (ge_s) begin
            sub_s = rem_r[23:0] - mb_r;
        end else begin
            sub_s = rem_r[23:0];
        end
    end

    // operand capture, unpack and iteration datapath
    always_ff @(posedge fp_clk) begin
        if (!reset_n) begin
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sign_r  <= 1'b0;
            cls_a_r <= ZERO;
            cls_b_r <= ZERO;
            mb_r    <= 24'd0;
            rem_r   <= 25'd0;
            q_r     <= '0;
            e_r     <= 10'sd0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
                        b_r <= B;
                    end
                end
                UNPACK: begin
                    sign_r  <= sa_s ^ sb_s;
                    cls_a_r <= ca_s;
                    cls_b_r <= cb_s;
                    mb_r    <= mb_s;
                    rem_r   <= {1'b0, ma_s};
                    q_r     <= '0;
                    e_r     <= ediff_s;
                    cnt_r   <= '0;
                end
                ITER: begin
                    rem_r <= {sub_s, 1'b0};
                    q_r   <= {q_r[QBITS-2:0], ge_s};
                    cnt_r <= cnt_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // normalise, round to nearest even, range-check and apply special cases.
    // For normal operands the quotient lies in (0.5, 2), so the hidden bit is
    // q[QBITS-1] or q[QBITS-2]; qn_s holds only the bits below it.
    always_comb begin
        if (q_r[QBITS-1]) begin
            qn_s = q_r[QBITS-2:0];
            en_s = e_r;
        end else begin
            qn_s = {q_r[QBITS-3:0], 1'b0};
            en_s = e_r - 10'sd1;
        end
        guard_s  = qn_s[QBITS-25];
        sticky_s = (|qn_s[QBITS-26:0]) | (|rem_r);
        inc_s    = guard_s & (sticky_s | qn_s[QBITS-24]);
        {carry_s, frac_s} = {1'b0, qn_s[QBITS-2 -: 23]} + {23'd0, inc_s};
        if (carry_s) begin
            ef_s = en_s + 10'sd1;
        end else begin
            ef_s = en_s;
        end

        if (cls_a_r == NAN || cls_b_r == NAN ||
            (cls_a_r == ZERO && cls_b_r == ZERO) ||
            (cls_a_r == INF && cls_b_r == INF)) begin
            result_s = QNAN;
        end else if (cls_b_r == ZERO || cls_a_r == INF) begin
            result_s = signed_inf(sign_r);
        end else if (cls_a_r == ZERO || cls_b_r == INF) begin
            result_s = signed_zero(sign_r);
        end else if (ef_s >= 10'sd255) begin
            result_s = signed_inf(sign_r);
        end else if (ef_s <= 10'sd0) begin
            result_s = signed_zero(sign_r);
        end else begin
            result_s = {sign_r, ef_s[7:0], frac_s};
        end
    end

    // registered handshake and result
    always_ff @(posedge fp_clk) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            out_r  <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                UNPACK: busy_r <= 1'b1;
                ROUND: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    out_r  <= result_s;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Out  = out_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed cases from the plan plus random operands
// checked against an integer-arithmetic reference divider.
module tb_fp_div_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] A, B;
    logic        start;
    logic        busy, done;
    logic [31:0] Out;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] val;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    fp_div_seq #(.QBITS(26)) dut (
        .fp_clk(clk), .reset_n(reset_n), .A(A), .B(B),
        .start(start), .busy(busy), .done(done), .Out(Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: exact integer quotient scaled by 2^30, rounded by comparing the
    // discarded part against one half.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [63:0] ma, mb, q, r, mant, low, half;
        bit za, zb, ia, ib, na, nb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC0_0000;
        if (zb || ia) return {s, 31'h7F80_0000};
        if (za || ib) return {s, 31'd0};
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        q  = (ma << 30) / mb;
        r  = (ma << 30) % mb;
        e  = ea - eb + 127;
        if (q >= (64'd1 << 30)) sh = 7;
        else begin
            sh = 6;
            e  = e - 1;
        end
        mant = q >> sh;
        low  = q & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (low > half || (low == half && (r != 64'd0 || mant[0]))) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {s, 31'h7F80_0000};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int kind;
        logic [31:0] v;
        kind = $urandom_range(0, 15);
        v = $urandom;
        case (kind)
            0: v[30:0] = 31'd0;
            1: v[30:0] = 31'h7F80_0000;
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        if (kind == 2 && v[22:0] == 23'd0) v[0] = 1'b1;
        return v;
    endfunction

    // monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1 with Out=%h expected no pending op", Out);
            end else begin
                e = sb_q.pop_front();
                check("out", Out, e.val);
                check("latency", 32'(cyc - e.acc), 32'd28);
            end
        end
    end

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv, input bit push);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        if (push) sb_q.push_back('{expv, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    logic [31:0] dir_a [8] = '{32'h3F80_0000, 32'h461C_4000, 32'hC0C0_0000, 32'h3F80_0000,
                               32'h0000_0000, 32'h0000_0000, 32'h7F00_0000, 32'h0080_0000};
    logic [31:0] dir_b [8] = '{32'h4040_0000, 32'h42C8_0000, 32'h4000_0000, 32'h0000_0000,
                               32'h0000_0000, 32'hBF80_0000, 32'h3E80_0000, 32'h4000_0000};
    logic [31:0] dir_q [8] = '{32'h3EAA_AAAB, 32'h42C8_0000, 32'hC040_0000, 32'h7F80_0000,
                               32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000};

    initial begin
        int bad;
        bit saw;
        reset_n = 1'b0;
        start   = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out", Out, 32'd0);
        reset_n = 1'b1;

        // 4/2 with the busy window traced edge by edge
        drive_op(32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1'b1);
        check("busy_after_accept", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check("busy_window", 32'(bad), 32'd0);
        @(negedge clk);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            drive_op(dir_a[i], dir_b[i], dir_q[i], 1'b1);
            wait_idle();
        end

        // a second start mid-operation is ignored
        drive_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b1);
        repeat (4) @(negedge clk);
        A = 32'h4080_0000;
        B = 32'h4000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (35) @(negedge clk);

        // start during the done cycle is accepted
        drive_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b1);
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        A = 32'h461C_4000;
        B = 32'h42C8_0000;
        start = 1'b1;
        sb_q.push_back('{32'h42C8_0000, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset at edge 10 of an operation
        drive_op(32'h4080_0000, 32'h4000_0000, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_out", Out, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        check("no_done_after_reset", {31'd0, saw}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = rand_op();
            b = rand_op();
            drive_op(a, b, ref_div(a, b), 1'b1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
